// File: rtl/modem_cfg_pkg.sv
// Shared types and constants for the modem configuration loader.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package modem_cfg_pkg;

    // Frame parser states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TYPE    = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_COMMIT  = 3'd4
    } cfg_state_e;

    // Frame bytes
    localparam logic [7:0] CFG_HDR      = 8'hA5;
    localparam logic [7:0] CFG_TYPE_KEY = 8'h01;
    localparam logic [7:0] CFG_TYPE_FCW = 8'h02;

    // Error codes reported on err_code
    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_CSUM = 2'd1;
    localparam logic [1:0] ERR_TYPE = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    // Power-on configuration so the modem runs without a host
    localparam logic [127:0] CFG_KEY_RST = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [31:0]  CFG_FCW_RST = 32'd68719477;

endpackage

// File: rtl/modem_cfg_loader.sv
// Parses A5/type/payload/checksum frames and atomically commits AES key / NCO FCW.
// Latency: outputs update one edge after the checksum edge (longer while cfg_hold is high).
// Backpressure: in_ready drops only in COMMIT, i.e. while a validated frame waits on cfg_hold.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid/in_ready  host byte link (transfer on valid && ready)
//   cfg_hold              datapath busy, defers the commit
//   key, fcw              live configuration (only changed by a commit)
//   cfg_update            one-cycle pulse on a commit
//   err_valid, err_code   one-cycle error pulse, sticky error code
//   busy                  parser is inside a frame
module modem_cfg_loader
    import modem_cfg_pkg::*;
#(
    parameter logic [127:0] KEY_RST     = CFG_KEY_RST,
    parameter logic [31:0]  FCW_RST     = CFG_FCW_RST,
    parameter int unsigned  TIMEOUT_CYC = 100000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         cfg_hold,
    output logic [127:0] key,
    output logic [31:0]  fcw,
    output logic         cfg_update,
    output logic         err_valid,
    output logic [1:0]   err_code,
    output logic         busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    cfg_state_e     r_state;
    cfg_state_e     w_state_nxt;
    logic [127:0]   r_stage;
    logic [7:0]     r_csum;
    logic [3:0]     r_cnt;
    logic           r_is_key;
    logic [TW-1:0]  r_tmo;

    logic           w_acc;
    logic           w_tmo_hit;
    logic           w_last;
    logic           w_counting;
    logic           w_commit;
    logic           w_err_set;
    logic [1:0]     w_err_code_nxt;

    assign in_ready   = (r_state != ST_COMMIT);
    assign busy       = (r_state != ST_IDLE);
    assign w_acc      = in_valid && in_ready;
    assign w_tmo_hit  = (r_tmo == TW'(TIMEOUT_CYC));
    assign w_last     = r_is_key ? (r_cnt == 4'd15) : (r_cnt == 4'd3);
    assign w_counting = (r_state == ST_TYPE) || (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, commit strobe and error detection.
    // An accepted byte always takes priority over an expiring timeout.
    always_comb begin
        w_state_nxt    = r_state;
        w_commit       = 1'b0;
        w_err_set      = 1'b0;
        w_err_code_nxt = ERR_NONE;
        case (r_state)
            ST_IDLE: begin
                if (w_acc && (in_data == CFG_HDR)) begin
                    w_state_nxt = ST_TYPE;
                end
            end
            ST_TYPE: begin
                if (w_acc) begin
                    if ((in_data == CFG_TYPE_KEY) || (in_data == CFG_TYPE_FCW)) begin
                        w_state_nxt = ST_PAYLOAD;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_TYPE;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TMO;
                end
            end
            ST_PAYLOAD: begin
                if (w_acc) begin
                    if (w_last) begin
                        w_state_nxt = ST_CHECK;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TMO;
                end
            end
            ST_CHECK: begin
                if (w_acc) begin
                    if (in_data == r_csum) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_state_nxt    = ST_IDLE;
                        w_err_set      = 1'b1;
                        w_err_code_nxt = ERR_CSUM;
                    end
                end else if (w_tmo_hit) begin
                    w_state_nxt    = ST_IDLE;
                    w_err_set      = 1'b1;
                    w_err_code_nxt = ERR_TMO;
                end
            end
            ST_COMMIT: begin
                if (!cfg_hold) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: staging, checksum, counters and the committed outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage    <= '0;
            r_csum     <= '0;
            r_cnt      <= '0;
            r_is_key   <= 1'b0;
            r_tmo      <= '0;
            key        <= KEY_RST;
            fcw        <= FCW_RST;
            cfg_update <= 1'b0;
            err_valid  <= 1'b0;
            err_code   <= ERR_NONE;
        end else begin
            cfg_update <= w_commit;
            err_valid  <= w_err_set;
            if (w_err_set) begin
                err_code <= w_err_code_nxt;
            end

            if (w_commit) begin
                if (r_is_key) begin
                    key <= r_stage;
                end else begin
                    fcw <= r_stage[31:0];
                end
            end

            // Idle-gap counter: only runs between bytes inside a frame
            if (!w_counting || w_acc || (w_state_nxt == ST_IDLE)) begin
                r_tmo <= '0;
            end else begin
                r_tmo <= r_tmo + TW'(1);
            end

            if (w_acc && (r_state == ST_TYPE)) begin
                r_cnt    <= '0;
                r_is_key <= (in_data == CFG_TYPE_KEY);
                r_csum   <= in_data;
            end

            if (w_acc && (r_state == ST_PAYLOAD)) begin
                r_stage <= {r_stage[119:0], in_data};
                r_csum  <= r_csum ^ in_data;
                r_cnt   <= r_cnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_modem_cfg_loader.sv
// Scoreboard bench for modem_cfg_loader: stimulus pushes expected events, a monitor checks them.
// Latency: n/a (testbench).
// Backpressure: byte sender waits on in_ready.
module tb_modem_cfg_loader;

    localparam int unsigned  TMO     = 40;
    localparam logic [127:0] KEY_DEF = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [31:0]  FCW_DEF = 32'd68719477;

    logic         clk;
    logic         rst_n;
    logic [7:0]   in_data;
    logic         in_valid;
    logic         in_ready;
    logic         cfg_hold;
    logic [127:0] key;
    logic [31:0]  fcw;
    logic         cfg_update;
    logic         err_valid;
    logic [1:0]   err_code;
    logic         busy;

    typedef struct {
        bit           is_err;
        logic [1:0]   code;
        logic [127:0] key;
        logic [31:0]  fcw;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    bit   rnd_hold = 0;

    // Reference configuration as the host believes it to be
    logic [127:0] m_key;
    logic [31:0]  m_fcw;

    modem_cfg_loader #(
        .KEY_RST    (KEY_DEF),
        .FCW_RST    (FCW_DEF),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .cfg_hold  (cfg_hold),
        .key       (key),
        .fcw       (fcw),
        .cfg_update(cfg_update),
        .err_valid (err_valid),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (rst_n && (cfg_update || err_valid)) begin
            exp_t e;
            n_checks++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: upd=%0b err=%0b code=%0d", cfg_update, err_valid, err_code);
            end else begin
                e = sb.pop_front();
                if (cfg_update && err_valid) begin
                    n_err++;
                    $display("FAIL pulse_overlap: both cfg_update and err_valid high");
                end else if (cfg_update) begin
                    if (e.is_err || key !== e.key || fcw !== e.fcw) begin
                        n_err++;
                        $display("FAIL update: got key=%h fcw=%h, expected is_err=%0b key=%h fcw=%h",
                                 key, fcw, e.is_err, e.key, e.fcw);
                    end
                end else begin
                    if (!e.is_err || err_code !== e.code || key !== e.key || fcw !== e.fcw) begin
                        n_err++;
                        $display("FAIL error: got code=%0d key=%h fcw=%h, expected is_err=%0b code=%0d key=%h fcw=%h",
                                 err_code, key, fcw, e.is_err, e.code, e.key, e.fcw);
                    end
                end
            end
        end
    end

    // Random hold generator, enabled only in the random section
    initial begin
        cfg_hold = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_hold) cfg_hold = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
        end
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    task automatic push_upd();
        exp_t e;
        e.is_err = 0; e.code = 2'd0; e.key = m_key; e.fcw = m_fcw;
        sb.push_back(e);
    endtask

    task automatic push_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1; e.code = code; e.key = m_key; e.fcw = m_fcw;
        sb.push_back(e);
    endtask

    // Transfer one byte after up to gmax idle cycles; caller is just past a posedge
    task automatic send(input logic [7:0] b, input int gmax);
        int  guard;
        bit  ok;
        repeat ($urandom_range(0, gmax)) @(posedge clk);
        #1;
        in_data  = b;
        in_valid = 1'b1;
        guard    = 0;
        do begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            guard++;
        end while (!ok && guard < 2000);
        #1;
        in_valid = 1'b0;
        if (!ok) begin
            n_checks++;
            n_err++;
            $display("FAIL send_stall: in_ready=0 for %0d cycles, expected acceptance", guard);
        end
    endtask

    // Frame with expectation computed from the frame rules: payload MSB first,
    // checksum = type ^ payload bytes; csum_xor != 0 corrupts the checksum.
    task automatic frame(input logic [7:0] typ, input logic [127:0] pay,
                         input logic [7:0] csum_xor, input int gmax);
        int         n;
        logic [7:0] cs;
        logic [7:0] bytes[16];
        n = (typ == 8'h01) ? 16 : (typ == 8'h02) ? 4 : 0;
        cs = typ;
        for (int i = 0; i < n; i++) begin
            bytes[i] = pay[8*(n-1-i) +: 8];
            cs ^= bytes[i];
        end
        if (n == 0) begin
            push_err(2'd2);
        end else if (csum_xor != 8'h00) begin
            push_err(2'd1);
        end else begin
            if (n == 16) m_key = pay;
            else         m_fcw = pay[31:0];
            push_upd();
        end
        send(8'hA5, gmax);
        send(typ, gmax);
        if (n != 0) begin
            for (int i = 0; i < n; i++) send(bytes[i], gmax);
            send(cs ^ csum_xor, gmax);
        end
    endtask

    initial begin
        logic [31:0] old_fcw;
        in_valid = 1'b0;
        in_data  = 8'h00;
        rst_n    = 1'b0;
        m_key    = KEY_DEF;
        m_fcw    = FCW_DEF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_key", key, KEY_DEF);
        chk("rst_fcw", {96'd0, fcw}, {96'd0, FCW_DEF});
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_cfg_update", {127'd0, cfg_update}, 128'd0);
        chk("rst_err_valid", {127'd0, err_valid}, 128'd0);
        chk("rst_err_code", {126'd0, err_code}, 128'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // FCW frame A5 02 00 00 10 00 12, with commit-latency spot checks
        frame(8'h02, 128'h00001000, 8'h00, 0);
        chk("commit_state_ready", {127'd0, in_ready}, 128'd0);
        chk("commit_fcw_not_yet", {96'd0, fcw}, {96'd0, FCW_DEF});
        @(posedge clk);
        #1;
        chk("commit_fcw", {96'd0, fcw}, 128'h00001000);
        chk("commit_pulse", {127'd0, cfg_update}, 128'd1);
        chk("commit_key_same", key, KEY_DEF);

        // Key frame A5 01 0F..00 01
        frame(8'h01, 128'h0f0e0d0c0b0a09080706050403020100, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("key_loaded", key, 128'h0f0e0d0c0b0a09080706050403020100);

        // Checksum 0x13 instead of 0x12, then a bad type
        frame(8'h02, 128'h00001000, 8'h01, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("csum_err_code", {126'd0, err_code}, 128'd1);
        frame(8'h07, 128'd0, 8'h00, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("type_err_code", {126'd0, err_code}, 128'd2);

        // Held commit: in_ready low and fcw stable for 20 cycles
        old_fcw  = fcw;
        cfg_hold = 1'b1;
        frame(8'h02, 128'h89abcdef, 8'h00, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("hold_ready", {127'd0, in_ready}, 128'd0);
            chk("hold_fcw", {96'd0, fcw}, {96'd0, old_fcw});
        end
        cfg_hold = 1'b0;
        @(posedge clk);
        #1;
        chk("hold_release_fcw", {96'd0, fcw}, 128'h89abcdef);

        // Timeout inside a frame, then a good frame
        push_err(2'd3);
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h00, 0);
        repeat (TMO + 4) @(posedge clk);
        #1;
        chk("tmo_code", {126'd0, err_code}, 128'd3);
        chk("tmo_idle", {127'd0, busy}, 128'd0);
        frame(8'h02, 128'h13572468, 8'h00, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("after_tmo_fcw", {96'd0, fcw}, 128'h13572468);

        // Randomized traffic: junk in idle, gaps, bad types, corrupted checksums, random hold
        rnd_hold = 1;
        for (int f = 0; f < 40; f++) begin
            int          sel;
            logic [7:0]  typ;
            logic [7:0]  cx;
            logic [127:0] pay;
            repeat ($urandom_range(0, 2)) begin
                logic [7:0] j;
                j = 8'($urandom);
                if (j == 8'hA5) j = 8'h5A;
                send(j, 1);
            end
            sel = $urandom_range(0, 9);
            typ = (sel < 4) ? 8'h01 : (sel < 8) ? 8'h02 : 8'($urandom_range(3, 255));
            pay = {$urandom, $urandom, $urandom, $urandom};
            cx  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            frame(typ, pay, cx, 3);
        end
        rnd_hold = 0;
        @(posedge clk);
        #1;
        cfg_hold = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rand_final_key", key, m_key);
        chk("rand_final_fcw", {96'd0, fcw}, {96'd0, m_fcw});

        // Reset while a validated frame waits in COMMIT: no update may leak out
        cfg_hold = 1'b1;
        send(8'hA5, 0);
        send(8'h02, 0);
        send(8'h00, 0);
        send(8'h00, 0);
        send(8'h10, 0);
        send(8'h00, 0);
        send(8'h12, 0);
        chk("pre_rst_commit_wait", {127'd0, in_ready}, 128'd0);
        rst_n = 1'b0;
        #1;
        m_key = KEY_DEF;
        m_fcw = FCW_DEF;
        chk("midrst_key", key, KEY_DEF);
        chk("midrst_fcw", {96'd0, fcw}, {96'd0, FCW_DEF});
        chk("midrst_busy", {127'd0, busy}, 128'd0);
        cfg_hold = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("post_rst_fcw", {96'd0, fcw}, {96'd0, FCW_DEF});

        n_checks++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: %0d expected events never seen, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
